score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Match-scoring stage directly upstream of the score-tally display.
- Samples ball position once per frame and detects goals at the left and right field limits.
- Keeps per-player scores, runs the serve/pause/game-over sequence, and drives the 5-segment tally masks the display block decodes into drawn points.
- All outputs change only on frame boundaries, so the display never tears mid-frame.

Parameters:
- WIN_SCORE, 5, score that ends the match (1..7); tally masks are 5 bits wide, so values above 5 saturate the mask.
- LEFT_LIMIT, 10'd8, ball_x at or below this is a goal for P2.
- RIGHT_LIMIT, 10'd632, ball_x at or above this is a goal for P1; must be greater than LEFT_LIMIT.
- PAUSE_FRAMES, 60, frame ticks held in PAUSE after a goal before re-serving (1..255).

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- start  in  1  one-cycle pulse, player start/restart request
- ball_x  in  10  current ball left-edge x position
- score_p1  out  3  P1 score
- score_p2  out  3  P2 score
- tally_p1  out  5  thermometer mask for P1 points; bit i set when score_p1 > i
- tally_p2  out  5  thermometer mask for P2 points
- ball_reset  out  1  one-cycle pulse: ball logic recentres and serves
- serve_dir  out  1  0 = serve toward P1 (left), 1 = toward P2 (right); valid when ball_reset pulses
- game_active  out  1  high in PLAY only; enables ball motion
- game_over  out  1  high in OVER
- winner  out  1  0 = P1, 1 = P2; valid while game_over

Behaviour:
- Reset values:
  - rst low forces state IDLE immediately (asynchronous), regardless of the current state, including mid-PAUSE or mid-OVER.
  - Scores 0, tallies 0, ball_reset 0, serve_dir 0, game_active 0, game_over 0, winner 0, pause counter 0.
- IDLE:
  - Outputs hold their reset values.
  - start -> PLAY. ball_reset pulses in the cycle after start, with serve_dir = 0.
- PLAY:
  - game_active = 1. ball_x is evaluated only in cycles where frame_tick = 1; ball_x is ignored in all other cycles.
  - ball_x <= LEFT_LIMIT: score_p2 increments on that clock edge, and serve_dir is latched to 0 (serve toward the player who conceded).
  - Otherwise, ball_x >= RIGHT_LIMIT: score_p1 increments, and serve_dir is latched to 1.
  - At most one goal per frame tick. The left check has priority; the right check is unreachable when it fires.
  - After a goal, the next state is OVER if the incremented score == WIN_SCORE; otherwise PAUSE with the pause counter cleared.
- PAUSE:
  - game_active = 0. The counter increments on each frame_tick.
  - When the counter reaches PAUSE_FRAMES-1 on a frame_tick: ball_reset pulses 1 cycle and the state goes to PLAY.
  - With PAUSE_FRAMES = 60, exactly 60 frame ticks elapse between the goal tick and the ball_reset pulse.
- OVER:
  - game_over = 1, game_active = 0. winner = 1 if score_p2 reached WIN_SCORE, else 0. Scores are frozen and goals are ignored.
  - start -> scores cleared, tallies cleared, state PLAY, ball_reset pulse with serve_dir = ~winner (the loser receives).
- start while in PLAY or PAUSE is ignored.
- Tally masks:
  - Registered, updated in the same edge as the score.
  - Mask = (1 << min(score, 5)) - 1; e.g. score 3 -> 5'b00111.
- Scores are 3-bit and never exceed WIN_SCORE. No wrap-around is reachable.
- ball_reset:
  - Registered single-cycle pulse.
  - Never asserted in the same cycle as a goal increment.
  - Never asserted on consecutive cycles.
- frame_tick and start in the same cycle:
  - In IDLE or OVER, start wins.
  - In PLAY or PAUSE, only frame_tick is acted on.

Test Plan:
- Reset then start -> one cycle later ball_reset = 1, serve_dir = 0, game_active = 1; scores 0, tallies 5'b00000.
- In PLAY, ball_x = 700 on a frame_tick -> score_p1 = 1, tally_p1 = 5'b00001, game_active = 0. After exactly 60 further frame_ticks -> ball_reset pulse, serve_dir = 1, game_active = 1.
- ball_x = 5 held for 3 frame_ticks in PLAY -> score_p2 increments exactly once (PAUSE blocks re-scoring). ball_x = 5 with frame_tick low for 1000 cycles -> no change.
- Drive P2 to 5 goals -> game_over = 1, winner = 1, tally_p2 = 5'b11111. Further goals ignored. start -> scores 0, ball_reset pulse with serve_dir = 0.
- Assert rst low mid-PAUSE (counter = 30) -> all outputs return to reset values asynchronously, before the next clk edge. Release, then start -> fresh PLAY with counter 0.
- start asserted in PLAY and in PAUSE -> no ball_reset and no score change. frame_tick and start coincident in OVER -> restart occurs and no goal is counted.

Source files
------------

// File: rtl/score_keeper.sv
// Match scoring for the pong field: detects goals once per frame, keeps player
// scores and tally masks, and sequences serve / pause / game-over.
module score_keeper #(
  parameter int         WIN_SCORE    = 5,
  parameter logic [9:0] LEFT_LIMIT   = 10'd8,
  parameter logic [9:0] RIGHT_LIMIT  = 10'd632,
  parameter int         PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic [4:0] tally_p1,
  output logic [4:0] tally_p2,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       game_active,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;

  localparam logic [2:0] WIN_Q      = 3'(WIN_SCORE);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

  state_t     state_q, state_d;
  logic [2:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [4:0] tally_p1_q, tally_p1_d, tally_p2_q, tally_p2_d;
  logic       ball_reset_q, ball_reset_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic [7:0] pause_cnt_q, pause_cnt_d;

  logic       goal_p1, goal_p2;
  logic [2:0] inc_p1, inc_p2;

  // Thermometer mask; scores above 5 simply saturate at all-ones.
  function automatic logic [4:0] tally_f(input logic [2:0] s);
    logic [4:0] m;
    for (int i = 0; i < 5; i++) m[i] = (s > 3'(i));
    return m;
  endfunction

  // Left limit has priority so at most one goal is seen per tick.
  assign goal_p2 = frame_tick && (ball_x <= LEFT_LIMIT);
  assign goal_p1 = frame_tick && !goal_p2 && (ball_x >= RIGHT_LIMIT);
  assign inc_p1  = score_p1_q + 3'd1;
  assign inc_p2  = score_p2_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    score_p1_d   = score_p1_q;
    score_p2_d   = score_p2_q;
    tally_p1_d   = tally_p1_q;
    tally_p2_d   = tally_p2_q;
    ball_reset_d = 1'b0;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    pause_cnt_d  = pause_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = PLAY;
          ball_reset_d = 1'b1;
          serve_dir_d  = 1'b0;
          pause_cnt_d  = 8'd0;
        end
      end
      PLAY: begin
        if (goal_p2) begin
          score_p2_d  = inc_p2;
          tally_p2_d  = tally_f(inc_p2);
          serve_dir_d = 1'b0;
          pause_cnt_d = 8'd0;
          if (inc_p2 == WIN_Q) begin
            state_d  = OVER;
            winner_d = 1'b1;
          end else begin
            state_d = PAUSE;
          end
        end else if (goal_p1) begin
          score_p1_d  = inc_p1;
          tally_p1_d  = tally_f(inc_p1);
          serve_dir_d = 1'b1;
          pause_cnt_d = 8'd0;
          if (inc_p1 == WIN_Q) begin
            state_d  = OVER;
            winner_d = 1'b0;
          end else begin
            state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (frame_tick) begin
          if (pause_cnt_q == PAUSE_LAST) begin
            state_d      = PLAY;
            ball_reset_d = 1'b1;
            pause_cnt_d  = 8'd0;
          end else begin
            pause_cnt_d = pause_cnt_q + 8'd1;
          end
        end
      end
      OVER: begin
        // The loser of the finished match receives the first serve.
        if (start) begin
          state_d      = PLAY;
          score_p1_d   = 3'd0;
          score_p2_d   = 3'd0;
          tally_p1_d   = 5'd0;
          tally_p2_d   = 5'd0;
          ball_reset_d = 1'b1;
          serve_dir_d  = ~winner_q;
          pause_cnt_d  = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      score_p1_q   <= 3'd0;
      score_p2_q   <= 3'd0;
      tally_p1_q   <= 5'd0;
      tally_p2_q   <= 5'd0;
      ball_reset_q <= 1'b0;
      serve_dir_q  <= 1'b0;
      winner_q     <= 1'b0;
      pause_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      tally_p1_q   <= tally_p1_d;
      tally_p2_q   <= tally_p2_d;
      ball_reset_q <= ball_reset_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      pause_cnt_q  <= pause_cnt_d;
    end
  end

  assign score_p1    = score_p1_q;
  assign score_p2    = score_p2_q;
  assign tally_p1    = tally_p1_q;
  assign tally_p2    = tally_p2_q;
  assign ball_reset  = ball_reset_q;
  assign serve_dir   = serve_dir_q;
  assign game_active = (state_q == PLAY);
  assign game_over   = (state_q == OVER);
  assign winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: serve, scoring, pause length, win/restart
// and asynchronous reset, with hand-computed expectations.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic [9:0] ball_x;
  logic [2:0] score_p1, score_p2;
  logic [4:0] tally_p1, tally_p2;
  logic       ball_reset, serve_dir, game_active, game_over, winner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .ball_x(ball_x),
    .score_p1(score_p1), .score_p2(score_p2), .tally_p1(tally_p1), .tally_p2(tally_p2),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .game_active(game_active),
    .game_over(game_over), .winner(winner)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic ftick(input logic [9:0] x);
    ball_x     = x;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    ball_x     = 10'd320;
    cyc();
  endtask

  // n neutral frame ticks; returns how many of them showed a ball_reset pulse
  task automatic neutral_ticks(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      ball_x     = 10'd320;
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      if (ball_reset !== 1'b0) pulses++;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; ball_x = 10'd320;
    #2 rst = 1'b0;
    cyc(); cyc();
    checks++;
    if ({score_p1, score_p2, tally_p1, tally_p2, ball_reset, serve_dir, game_active, game_over, winner} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {score_p1, score_p2, tally_p1, tally_p2, ball_reset, serve_dir, game_active, game_over, winner});
    end
    #3 rst = 1'b1;
    cyc();
    checks++;
    if (game_active !== 1'b0 || ball_reset !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: active=%b reset=%b required 0 0", game_active, ball_reset);
    end
  endtask

  task automatic test_start();
    pulse_start();
    checks++;
    if (ball_reset !== 1'b1 || serve_dir !== 1'b0 || game_active !== 1'b1) begin
      errors++;
      $display("FAIL start_serve: reset=%b dir=%b active=%b required 1 0 1", ball_reset, serve_dir, game_active);
    end
    checks++;
    if (score_p1 !== 3'd0 || score_p2 !== 3'd0 || tally_p1 !== 5'd0 || tally_p2 !== 5'd0) begin
      errors++;
      $display("FAIL start_scores: %0d %0d %b %b required 0 0 00000 00000", score_p1, score_p2, tally_p1, tally_p2);
    end
    cyc();
    checks++;
    if (ball_reset !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse_width: got %b required 0", ball_reset);
    end
  endtask

  task automatic test_p1_goal_pause();
    int early;
    ball_x = 10'd700; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0; ball_x = 10'd320;
    checks++;
    if (score_p1 !== 3'd1 || tally_p1 !== 5'b00001 || game_active !== 1'b0 || serve_dir !== 1'b1) begin
      errors++;
      $display("FAIL p1_goal: score=%0d tally=%b active=%b dir=%b required 1 00001 0 1",
               score_p1, tally_p1, game_active, serve_dir);
    end
    cyc();
    neutral_ticks(59, early);
    checks++;
    if (early !== 0 || game_active !== 1'b0) begin
      errors++;
      $display("FAIL pause_early: pulses=%0d active=%b required 0 0", early, game_active);
    end
    ball_x = 10'd320; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    checks++;
    if (ball_reset !== 1'b1 || serve_dir !== 1'b1 || game_active !== 1'b1) begin
      errors++;
      $display("FAIL pause_60th: reset=%b dir=%b active=%b required 1 1 1", ball_reset, serve_dir, game_active);
    end
    cyc();
  endtask

  task automatic test_p2_hold();
    int dummy;
    ftick(10'd5);
    ftick(10'd5);
    ftick(10'd5);
    checks++;
    if (score_p2 !== 3'd1 || tally_p2 !== 5'b00001 || serve_dir !== 1'b0) begin
      errors++;
      $display("FAIL p2_held_once: score=%0d tally=%b dir=%b required 1 00001 0", score_p2, tally_p2, serve_dir);
    end
    neutral_ticks(58, dummy);
    checks++;
    if (game_active !== 1'b1) begin
      errors++;
      $display("FAIL p2_reserve: active=%b required 1", game_active);
    end
    ball_x = 10'd5;
    repeat (1000) cyc();
    ball_x = 10'd320;
    checks++;
    if (score_p2 !== 3'd1 || score_p1 !== 3'd1 || game_active !== 1'b1) begin
      errors++;
      $display("FAIL no_tick_no_goal: p1=%0d p2=%0d active=%b required 1 1 1", score_p1, score_p2, game_active);
    end
  endtask

  task automatic test_start_ignored();
    int dummy;
    pulse_start();
    checks++;
    if (ball_reset !== 1'b0 || score_p1 !== 3'd1 || score_p2 !== 3'd1 || game_active !== 1'b1) begin
      errors++;
      $display("FAIL start_in_play: reset=%b p1=%0d p2=%0d active=%b required 0 1 1 1",
               ball_reset, score_p1, score_p2, game_active);
    end
    ftick(10'd5);
    pulse_start();
    checks++;
    if (ball_reset !== 1'b0 || score_p2 !== 3'd2 || game_active !== 1'b0) begin
      errors++;
      $display("FAIL start_in_pause: reset=%b p2=%0d active=%b required 0 2 0", ball_reset, score_p2, game_active);
    end
    neutral_ticks(60, dummy);
  endtask

  task automatic test_p2_win();
    int dummy;
    ftick(10'd5);
    neutral_ticks(60, dummy);
    ftick(10'd5);
    neutral_ticks(60, dummy);
    ftick(10'd0);
    checks++;
    if (game_over !== 1'b1 || winner !== 1'b1 || game_active !== 1'b0) begin
      errors++;
      $display("FAIL p2_win_flags: over=%b winner=%b active=%b required 1 1 0", game_over, winner, game_active);
    end
    checks++;
    if (score_p2 !== 3'd5 || tally_p2 !== 5'b11111 || score_p1 !== 3'd1 || tally_p1 !== 5'b00001) begin
      errors++;
      $display("FAIL p2_win_scores: p2=%0d t2=%b p1=%0d t1=%b required 5 11111 1 00001",
               score_p2, tally_p2, score_p1, tally_p1);
    end
    ftick(10'd700);
    ftick(10'd5);
    checks++;
    if (score_p1 !== 3'd1 || score_p2 !== 3'd5 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_frozen: p1=%0d p2=%0d over=%b required 1 5 1", score_p1, score_p2, game_over);
    end
  endtask

  task automatic test_restart_coincident();
    start = 1'b1; frame_tick = 1'b1; ball_x = 10'd700;
    cyc();
    start = 1'b0; frame_tick = 1'b0; ball_x = 10'd320;
    checks++;
    if (ball_reset !== 1'b1 || serve_dir !== 1'b0 || game_active !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart_flags: reset=%b dir=%b active=%b over=%b required 1 0 1 0",
               ball_reset, serve_dir, game_active, game_over);
    end
    checks++;
    if (score_p1 !== 3'd0 || score_p2 !== 3'd0 || tally_p1 !== 5'd0 || tally_p2 !== 5'd0) begin
      errors++;
      $display("FAIL restart_scores: %0d %0d %b %b required 0 0 00000 00000", score_p1, score_p2, tally_p1, tally_p2);
    end
    cyc();
  endtask

  task automatic test_p1_win();
    int dummy;
    for (int g = 0; g < 4; g++) begin
      ftick(10'd632);
      neutral_ticks(60, dummy);
    end
    ftick(10'd1023);
    checks++;
    if (game_over !== 1'b1 || winner !== 1'b0 || score_p1 !== 3'd5 || tally_p1 !== 5'b11111 || score_p2 !== 3'd0) begin
      errors++;
      $display("FAIL p1_win: over=%b winner=%b p1=%0d t1=%b p2=%0d required 1 0 5 11111 0",
               game_over, winner, score_p1, tally_p1, score_p2);
    end
    pulse_start();
    checks++;
    if (ball_reset !== 1'b1 || serve_dir !== 1'b1 || score_p1 !== 3'd0) begin
      errors++;
      $display("FAIL p1_restart: reset=%b dir=%b p1=%0d required 1 1 0", ball_reset, serve_dir, score_p1);
    end
    cyc();
  endtask

  task automatic test_reset_mid_pause();
    int dummy;
    int early;
    ftick(10'd700);
    neutral_ticks(30, dummy);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({score_p1, score_p2, tally_p1, tally_p2, ball_reset, serve_dir, game_active, game_over, winner} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset: got %b required all zero",
               {score_p1, score_p2, tally_p1, tally_p2, ball_reset, serve_dir, game_active, game_over, winner});
    end
    cyc();
    #2 rst = 1'b1;
    cyc();
    pulse_start();
    checks++;
    if (ball_reset !== 1'b1 || serve_dir !== 1'b0 || game_active !== 1'b1) begin
      errors++;
      $display("FAIL reset_then_start: reset=%b dir=%b active=%b required 1 0 1", ball_reset, serve_dir, game_active);
    end
    cyc();
    ftick(10'd700);
    neutral_ticks(59, early);
    ball_x = 10'd320; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    checks++;
    if (early !== 0 || ball_reset !== 1'b1 || score_p1 !== 3'd1) begin
      errors++;
      $display("FAIL fresh_pause: early=%0d reset=%b p1=%0d required 0 1 1", early, ball_reset, score_p1);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_p1_goal_pause();
    test_p2_hold();
    test_start_ignored();
    test_p2_win();
    test_restart_coincident();
    test_p1_win();
    test_reset_mid_pause();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
